// File: rtl/mem_copy_engine_if.sv
// Bundle of the copy engine's control handshake and its single-port memory bus.
// The master modport is the engine side; the slave modport is the CPU/memory side.
interface mem_copy_engine_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 11
);
    logic              start;
    logic              abort;
    logic              fill;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [31:0]       fill_val;
    logic              busy;
    logic              done;
    logic [31:0]       mem_addr;
    logic              mem_we;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    modport master (
        input  start, abort, fill, src, dst, len, fill_val, mem_dout,
        output busy, done, mem_addr, mem_we, mem_din
    );

    modport slave (
        output start, abort, fill, src, dst, len, fill_val, mem_dout,
        input  busy, done, mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-move / block-fill engine: copies LEN words SRC->DST (ascending, 2 cycles/word)
// or fills DST with a constant (1 cycle/word) over a single-port memory.
module mem_copy_engine #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_copy_engine_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;

    logic              fill_l;
    logic [ADDR_W-1:0] src_l;
    logic [ADDR_W-1:0] dst_l;
    logic [LEN_W-1:0]  len_l;
    logic [31:0]       fill_val_l;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_inc;
    logic [31:0]       data_buf;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W-1:0] addr_c;
    logic              we_c;
    logic [31:0]       din_c;

    assign idx_inc = idx + LEN_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; abort only cancels the active RD/WR phases
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        state_n = FIN;
                    end else if (bus.fill) begin
                        state_n = WR;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD: begin
                state_n = bus.abort ? IDLE : WR;
            end
            WR: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (idx_inc == len_l) begin
                    state_n = FIN;
                end else begin
                    state_n = fill_l ? WR : RD;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Memory-bus outputs; address and data hold their last value when inactive
    always_comb begin
        addr_c = addr_q;
        we_c   = 1'b0;
        din_c  = din_q;
        unique case (state)
            RD: begin
                addr_c = src_l + ADDR_W'(idx);
            end
            WR: begin
                addr_c = dst_l + ADDR_W'(idx);
                we_c   = ~bus.abort;
                din_c  = fill_l ? fill_val_l : data_buf;
            end
            default: begin
                addr_c = addr_q;
            end
        endcase
    end

    // Latched request, index, read buffer and registered status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_l     <= 1'b0;
            src_l      <= '0;
            dst_l      <= '0;
            len_l      <= '0;
            fill_val_l <= '0;
            idx        <= '0;
            data_buf   <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            busy_q <= (state_n != IDLE);
            done_q <= (state_n == FIN);
            if (state == IDLE && bus.start) begin
                fill_l     <= bus.fill;
                src_l      <= bus.src;
                dst_l      <= bus.dst;
                len_l      <= bus.len;
                fill_val_l <= bus.fill_val;
                idx        <= '0;
            end
            if (state == RD) begin
                data_buf <= bus.mem_dout;
                addr_q   <= addr_c;
            end
            if (state == WR) begin
                addr_q <= addr_c;
                din_q  <= din_c;
                if (!bus.abort) begin
                    idx <= idx_inc;
                end
            end
        end
    end

    assign bus.mem_addr = 32'(addr_c);
    assign bus.mem_we   = we_c;
    assign bus.mem_din  = din_c;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a reference memory model predicts every write,
// a negedge monitor pops and compares each observed write.
module tb_mem_copy_engine;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 11;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_copy_engine_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    mem_copy_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_wr    = 0;

    assign bus.mem_dout = mem[bus.mem_addr[ADDR_W-1:0]];

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr[ADDR_W-1:0]] <= bus.mem_din;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each observed write must match the oldest predicted write
    always @(negedge clk) begin
        if (reset_n && bus.mem_we === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bus.mem_addr), 64'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
                check("wr_data", 64'(bus.mem_din), 64'(mon_e.data));
            end
        end
    end

    task automatic poke(input int a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Forward, word-by-word reference of the first nwr writes of a transfer
    task automatic plan(input bit fill, input int src, input int dst, input logic [31:0] fv,
                        input int nwr);
        wr_t e;
        for (int k = 0; k < nwr; k++) begin
            e.addr = 32'((dst + k) & (DEPTH - 1));
            e.data = fill ? fv : ref_mem[(src + k) & (DEPTH - 1)];
            ref_mem[e.addr[ADDR_W-1:0]] = e.data;
            exp_q.push_back(e);
        end
    endtask

    task automatic xfer(input string tag, input bit fill, input int src, input int dst,
                        input int len, input logic [31:0] fv, input int nwr,
                        input int exp_busy, input int exp_done, input int abort_at,
                        input int restart_at, input bit abort_with_start);
        int busy_cnt = 0;
        int done_cnt = 0;
        int wr0      = n_wr;
        bit fin      = 1'b0;
        plan(fill, src, dst, fv, nwr);
        @(posedge clk); #1;
        bus.fill     = fill;
        bus.src      = ADDR_W'(src);
        bus.dst      = ADDR_W'(dst);
        bus.len      = LEN_W'(len);
        bus.fill_val = fv;
        bus.start    = 1'b1;
        bus.abort    = abort_with_start;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(posedge clk); #1;
            bus.start = (c == restart_at);
            bus.abort = (c == abort_at);
            if (c == restart_at) begin
                bus.dst  = ADDR_W'(600);
                bus.len  = LEN_W'(5);
                bus.fill = 1'b1;
            end
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.busy !== 1'b1) fin = 1'b1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (!fin) check({tag, "_timeout"}, 64'd1, 64'd0);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'(exp_done));
        check({tag, "_write_count"}, 64'(n_wr - wr0), 64'(nwr));
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int mism;
        wr_t e;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.fill = 1'b0;
        bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill_val = '0;

        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_we", 64'(bus.mem_we), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_din", 64'(bus.mem_din), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        poke(4, 32'hA); poke(5, 32'hB); poke(6, 32'hC); poke(7, 32'hD);
        xfer("copy", 1'b0, 4, 20, 4, 32'h0, 4, 9, 1, -1, -1, 1'b0);
        check("copy_d20", 64'(mem[20]), 64'hA);
        check("copy_d21", 64'(mem[21]), 64'hB);
        check("copy_d22", 64'(mem[22]), 64'hC);
        check("copy_d23", 64'(mem[23]), 64'hD);
        check("copy_s4", 64'(mem[4]), 64'hA);
        check("copy_s7", 64'(mem[7]), 64'hD);

        xfer("fill_wrap", 1'b1, 0, 1022, 4, 32'hDEADBEEF, 4, 5, 1, -1, -1, 1'b0);
        check("fill_1022", 64'(mem[1022]), 64'hDEADBEEF);
        check("fill_1023", 64'(mem[1023]), 64'hDEADBEEF);
        check("fill_0", 64'(mem[0]), 64'hDEADBEEF);
        check("fill_1", 64'(mem[1]), 64'hDEADBEEF);

        xfer("len0", 1'b0, 0, 50, 0, 32'h0, 0, 1, 1, 0, -1, 1'b1);

        xfer("ign_start", 1'b0, 4, 40, 3, 32'h0, 3, 7, 1, -1, 1, 1'b0);
        check("ign_d40", 64'(mem[40]), 64'hA);
        check("ign_d42", 64'(mem[42]), 64'hC);
        check("ign_600", 64'(mem[600]), 64'h0);

        poke(0, 32'd1); poke(1, 32'd2); poke(2, 32'd3); poke(3, 32'd4);
        xfer("overlap", 1'b0, 0, 1, 3, 32'h0, 3, 7, 1, -1, -1, 1'b0);
        for (int k = 0; k < 4; k++) check($sformatf("overlap_m%0d", k), 64'(mem[k]), 64'd1);

        for (int k = 0; k < 8; k++) poke(200 + k, 32'h1000 + 32'(k));
        xfer("abort", 1'b0, 200, 300, 8, 32'h0, 1, 4, 0, 3, -1, 1'b0);
        check("abort_m300", 64'(mem[300]), 64'h1000);
        check("abort_m301", 64'(mem[301]), 64'h0);
        xfer("after_abort", 1'b0, 202, 310, 2, 32'h0, 2, 5, 1, -1, -1, 1'b0);
        check("after_m311", 64'(mem[311]), 64'h1003);

        // Reset during a write cycle: outputs clear at once, write is dropped
        e.addr = 32'd100; e.data = 32'h5A5A5A5A;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.fill = 1'b1; bus.dst = ADDR_W'(100); bus.len = LEN_W'(8);
        bus.fill_val = 32'h5A5A5A5A; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("midwr_we", 64'(bus.mem_we), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_we", 64'(bus.mem_we), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_addr", 64'(bus.mem_addr), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("arst_m100", 64'(mem[100]), 64'h0);
        reset_n = 1'b1;
        check("arst_sb_empty", 64'(exp_q.size()), 64'd0);

        mism = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== ref_mem[i]) mism++;
        check("mem_vs_model", 64'(mism), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
